// File: rtl/mem_addr_arbiter.sv
// Registered address arbiter: grants one of NUM_CH requesters the shared memory
// address bus, with fixed-priority or round-robin policy, per-channel lock and global stall.
module mem_addr_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_CH     = 2,
    parameter int ARB_MODE   = 0,
    parameter int IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            req,
    input  logic [NUM_CH-1:0]            lock,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] addr_in,
    input  logic                         stall,
    output logic [NUM_CH-1:0]            gnt,
    output logic [IDX_W-1:0]             owner,
    output logic [ADDR_WIDTH-1:0]        addr_out,
    output logic                         addr_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_CH-1:0]       gnt_q, gnt_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    valid_q, valid_d;
    logic [IDX_W-1:0]        rr_last_q, rr_last_d;

    logic win_found;
    int   win_idx;
    int   start_idx;
    int   probe;
    logic locked;

    // Search order starts at 0 (fixed) or one past the last winner (round-robin).
    always_comb begin
        win_found = 1'b0;
        win_idx   = 0;
        start_idx = 0;
        probe     = 0;
        if (ARB_MODE == 1) begin
            start_idx = (int'(rr_last_q) + 1) % NUM_CH;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            probe = start_idx + i;
            if (probe >= NUM_CH) begin
                probe = probe - NUM_CH;
            end
            if (!win_found && req[probe]) begin
                win_found = 1'b1;
                win_idx   = probe;
            end
        end
    end

    assign locked = (state_q == OWNED) && req[owner_q] && lock[owner_q];

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        valid_d   = valid_q;
        rr_last_d = rr_last_q;
        if (!stall) begin
            if (locked) begin
                // Locked owner keeps the bus; address tracks its source every cycle.
                addr_d = addr_in[int'(owner_q)*ADDR_WIDTH +: ADDR_WIDTH];
            end else if (win_found) begin
                state_d   = OWNED;
                gnt_d     = NUM_CH'(1) << win_idx;
                owner_d   = IDX_W'(win_idx);
                addr_d    = addr_in[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                valid_d   = 1'b1;
                rr_last_d = IDX_W'(win_idx);
            end else begin
                // Owner and address are held so the bus keeps its last value.
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            rr_last_q <= IDX_W'(NUM_CH - 1);
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            rr_last_q <= rr_last_d;
        end
    end

    assign gnt        = gnt_q;
    assign owner      = owner_q;
    assign addr_out   = addr_q;
    assign addr_valid = valid_q;

endmodule

// File: tb/tb_mem_addr_arbiter.sv
// Directed bench: a fixed-priority and a round-robin arbiter (4 channels, 5-bit
// addresses) share one stimulus stream; each is checked against hand-computed values.
module tb_mem_addr_arbiter;

    localparam int AW = 5;
    localparam int NC = 4;
    localparam int IW = 2;

    logic          clk;
    logic          rst;
    logic [NC-1:0] req;
    logic [NC-1:0] lock;
    logic [AW-1:0] a [NC];
    logic [NC*AW-1:0] addr_in;
    logic          stall;

    logic [NC-1:0] gnt_fp, gnt_rr;
    logic [IW-1:0] owner_fp, owner_rr;
    logic [AW-1:0] addr_fp, addr_rr;
    logic          valid_fp, valid_rr;

    int n_checks;
    int n_fail;

    assign addr_in = {a[3], a[2], a[1], a[0]};

    mem_addr_arbiter #(.ADDR_WIDTH(AW), .NUM_CH(NC), .ARB_MODE(0)) u_fp (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .addr_in(addr_in), .stall(stall),
        .gnt(gnt_fp), .owner(owner_fp), .addr_out(addr_fp), .addr_valid(valid_fp)
    );

    mem_addr_arbiter #(.ADDR_WIDTH(AW), .NUM_CH(NC), .ARB_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .addr_in(addr_in), .stall(stall),
        .gnt(gnt_rr), .owner(owner_rr), .addr_out(addr_rr), .addr_valid(valid_rr)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Checks gnt/addr_out/addr_valid of both instances.
    task automatic check_out(input string tag,
                             input logic [NC-1:0] eg_fp, input logic [AW-1:0] ea_fp,
                             input logic [NC-1:0] eg_rr, input logic [AW-1:0] ea_rr);
        check_eq({tag, " fp gnt"},   32'(gnt_fp),   32'(eg_fp));
        check_eq({tag, " fp addr"},  32'(addr_fp),  32'(ea_fp));
        check_eq({tag, " fp valid"}, 32'(valid_fp), 32'(eg_fp != '0));
        check_eq({tag, " rr gnt"},   32'(gnt_rr),   32'(eg_rr));
        check_eq({tag, " rr addr"},  32'(addr_rr),  32'(ea_rr));
        check_eq({tag, " rr valid"}, 32'(valid_rr), 32'(eg_rr != '0));
    endtask

    logic [NC-1:0] rr_seq [5];
    logic [AW-1:0] rr_aseq [5];
    logic [NC-1:0] rr_seq2 [4];
    logic [AW-1:0] rr_aseq2 [4];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        req   = 4'b1111;
        lock  = 4'b0000;
        stall = 1'b0;
        a[0] = 5'h03; a[1] = 5'h1A; a[2] = 5'h12; a[3] = 5'h13;

        // reset held two cycles with all requests up
        step();
        step();
        check_out("reset", 4'b0000, 5'h00, 4'b0000, 5'h00);
        check_eq("reset fp owner", 32'(owner_fp), 32'd0);
        check_eq("reset rr owner", 32'(owner_rr), 32'd0);

        rst = 1'b0;
        step();
        check_out("first grant", 4'b0001, 5'h03, 4'b0001, 5'h03);

        // all requesting: fixed stays on ch0, round-robin rotates with wrap
        rr_seq  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        rr_aseq = '{5'h1A, 5'h12, 5'h13, 5'h03, 5'h1A};
        for (int i = 0; i < 5; i++) begin
            step();
            check_out($sformatf("all_req %0d", i), 4'b0001, 5'h03, rr_seq[i], rr_aseq[i]);
        end

        // ch0 silent: fixed stays on ch1, round-robin continues from ch2
        req = 4'b1110;
        rr_seq2  = '{4'b0100, 4'b1000, 4'b0010, 4'b0100};
        rr_aseq2 = '{5'h12, 5'h13, 5'h1A, 5'h12};
        for (int i = 0; i < 4; i++) begin
            step();
            check_out($sformatf("prio %0d", i), 4'b0010, 5'h1A, rr_seq2[i], rr_aseq2[i]);
        end

        // single request then drop: address held while idle
        req = 4'b0010;
        step();
        check_out("single", 4'b0010, 5'h1A, 4'b0010, 5'h1A);
        req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("idle hold %0d", i), 4'b0000, 5'h1A, 4'b0000, 5'h1A);
        end
        check_eq("idle fp owner", 32'(owner_fp), 32'd1);
        check_eq("idle rr owner", 32'(owner_rr), 32'd1);

        // lock on ch1 with a stepping address while ch0 also requests
        req  = 4'b0010;
        lock = 4'b0010;
        a[1] = 5'h04;
        step();
        check_out("lock 04", 4'b0010, 5'h04, 4'b0010, 5'h04);
        req = 4'b0011;
        for (int i = 1; i < 4; i++) begin
            a[1] = AW'(4 + i);
            step();
            check_out($sformatf("lock %0d", i), 4'b0010, AW'(4 + i), 4'b0010, AW'(4 + i));
        end
        lock = 4'b0000;
        step();
        check_out("unlock", 4'b0001, 5'h03, 4'b0001, 5'h03);

        // stall during ownership: everything frozen despite input changes
        stall = 1'b1;
        req   = 4'b1100;
        a[0]  = 5'h1F;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("stall %0d", i), 4'b0001, 5'h03, 4'b0001, 5'h03);
            check_eq($sformatf("stall fp owner %0d", i), 32'(owner_fp), 32'd0);
        end
        stall = 1'b0;
        step();
        check_out("unstall", 4'b0100, 5'h12, 4'b0100, 5'h12);
        check_eq("unstall rr owner", 32'(owner_rr), 32'd2);

        // reset while owned
        rst = 1'b1;
        step();
        check_out("mid reset", 4'b0000, 5'h00, 4'b0000, 5'h00);
        check_eq("mid reset owner", 32'(owner_fp), 32'd0);
        rst = 1'b0;
        req = 4'b0100;
        step();
        check_out("post reset", 4'b0100, 5'h12, 4'b0100, 5'h12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_addr_arbiter.md
# mem_addr_arbiter

Registered, parametrised memory-address arbiter that selects one of NUM_CH address sources (instruction fetch, data access, DMA, …) and drives the single shared memory address bus. It replaces the combinational two-source address select with clocked arbitration, a held address when idle, and fixed-priority or round-robin policy. It also supports bus locking for multi-cycle accesses and a global stall. It sits between the PC/datapath address generators and the unified memory.

## Interface
- ADDR_WIDTH, 5: width of every address source and of addr_out (legal 1..16).
- NUM_CH, 2: number of requesting channels (legal 2..8); channel 0 = instruction fetch, channel 1 = data.
- ARB_MODE, 0: 0 = fixed priority (lower index wins), 1 = round-robin.
- IDX_W, derived: max(1, clog2(NUM_CH)); not to be overridden.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_CH  per-channel access request, level-sensitive.
- lock  in  NUM_CH  per-channel lock; keeps ownership while that channel's req stays high.
- addr_in  in  NUM_CH*ADDR_WIDTH  flattened sources; channel k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- stall  in  1  freeze: no arbitration, all outputs held.
- gnt  out  NUM_CH  one-hot grant, registered.
- owner  out  IDX_W  index of the current or last granted channel.
- addr_out  out  ADDR_WIDTH  registered memory address.
- addr_valid  out  1  high when gnt is non-zero.

## Operation
- Reset values (on rst, clock edge): state IDLE, gnt 0, owner 0, addr_out 0, addr_valid 0. The round-robin pointer is set so channel 0 has top priority. rst overrides stall and all requests.
- FSM states: IDLE (no grant) and OWNED (exactly one gnt bit set).
- IDLE, stall=0, any req set:
  - Go to OWNED with the arbitration winner w.
  - gnt becomes one-hot w, owner becomes w, addr_out becomes addr_in[w], addr_valid becomes 1.
- IDLE, no req set or stall=1: stay in IDLE. addr_out keeps its last value (held address); it is never cleared except by reset.
- OWNED, stall=1: stay; gnt, owner, addr_out and addr_valid are all frozen.
- OWNED, stall=0, req[owner]=1 and lock[owner]=1: stay with the same owner. addr_out is reloaded from addr_in[owner] every cycle, so it tracks an incrementing source. No re-arbitration occurs.
- OWNED, stall=0, otherwise: re-arbitrate over the current req.
  - Winner found: grant moves to it in the next cycle, with no idle gap.
  - No requester: go to IDLE; gnt becomes 0, addr_valid becomes 0, addr_out and owner hold.
- Arbitration policy:
  - Fixed priority: the lowest set req index wins.
  - Round-robin: the search starts at (last winner + 1) mod NUM_CH and wraps. The pointer advances only when a new grant is issued, not on locked cycles.
- Without lock, a granted channel holds the bus for exactly one cycle if any other channel is requesting. Under fixed priority it may be re-granted if it is still the highest-priority requester.
- Dropping lock while req stays high releases ownership at the next re-arbitration cycle.
- Contract, not checked: lock bits of non-owner channels are ignored. addr_in of non-winning channels has no effect.

## Timing
- Latency is 1 cycle: req sampled at edge N gives gnt/addr_out/addr_valid valid after edge N (cycle N+1).
- Deassertion: when req[owner] drops, gnt drops or moves to the next winner on the following edge.
- stall is sampled each edge. The cycle after stall falls, normal FSM evaluation resumes using the req/lock values sampled at that edge.
- Reset mid-OWNED clears the grant on the reset edge. The first grant can appear one edge after rst deasserts.
- Fully synchronous outputs; there is no combinational path from inputs to outputs.

## Test plan
- Reset: hold rst for 2 cycles with req=all-ones and ADDR_WIDTH=5 -> gnt=0, addr_out=5'h00, addr_valid=0, owner=0. Release rst -> next cycle gnt=01, addr_out=addr_in[0].
- Single request and hold: req=10, addr_in[1]=5'h1A -> next cycle gnt=10, addr_out=5'h1A. Drop req -> gnt=00, addr_valid=0, addr_out stays 5'h1A indefinitely.
- Fixed priority (ARB_MODE=0, NUM_CH=4): req=1110 continuously -> gnt=0010 every cycle; channels 2 and 3 are never granted.
- Round-robin (ARB_MODE=1, NUM_CH=4): req=1111 continuously -> gnt sequence 0001, 0010, 0100, 1000, 0001, with wrap and no gaps.
- Lock: channel 1 granted with lock[1]=1 and addr_in[1] stepping 5'h04..5'h07 over 4 cycles while req[0]=1 -> gnt stays 10, addr_out follows 04..07. Clear lock[1] -> grant moves to 01 next cycle.
- Stall and reset mid-operation: assert stall for 3 cycles during OWNED while changing req/addr_in -> all outputs frozen. Assert rst during OWNED -> gnt=0, addr_out=0 after that edge.
